// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared types and widths for the shared-adder scheduler
package adder_sched_pkg;
    localparam int ADD_W = 16;
    localparam int OP_W  = 2 * ADD_W;

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic            wide;
        logic            id;
    } req_t;
endpackage

// File: rtl/adder_sched_if.sv
// adder_sched_if: two request channels plus the tagged response channel
interface adder_sched_if;
    import adder_sched_pkg::*;
    logic            req0_valid, req0_ready, req0_wide;
    logic [OP_W-1:0] req0_a, req0_b;
    logic            req1_valid, req1_ready, req1_wide;
    logic [OP_W-1:0] req1_a, req1_b;
    logic            resp_valid, resp_ready, resp_id, resp_carry, busy;
    logic [OP_W-1:0] resp_sum;

    modport master (
        output req0_valid, req0_a, req0_b, req0_wide,
        output req1_valid, req1_a, req1_b, req1_wide,
        output resp_ready,
        input  req0_ready, req1_ready, resp_valid, resp_id, resp_sum, resp_carry, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_wide,
        input  req1_valid, req1_a, req1_b, req1_wide,
        input  resp_ready,
        output req0_ready, req1_ready, resp_valid, resp_id, resp_sum, resp_carry, busy
    );
endinterface

// File: rtl/adder_sched_add16_core.sv
// add16_core: combinational 16-bit ripple-carry adder built from full adders
module add16_core
    import adder_sched_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             cin,
    output logic [ADD_W-1:0] sum,
    output logic             cout
);
    logic [ADD_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < ADD_W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[ADD_W];
endmodule

// File: rtl/adder_sched.sv
// adder_sched: round-robin arbiter sequencing 16/32-bit adds through one 16-bit core
module adder_sched
    import adder_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    adder_sched_if.slave bus
);
    state_t           state;
    req_t             r;
    logic             ptr, carry, g1, idle, core_cin, core_cout;
    logic [ADD_W-1:0] sum_lo, sum_hi, core_a, core_b, core_sum;

    // ready is held low while rst is asserted so the reset view is all-zero
    assign idle           = state == IDLE && !rst;
    assign g1             = bus.req1_valid && (!bus.req0_valid || ptr);
    assign bus.req0_ready = idle && bus.req0_valid && !g1;
    assign bus.req1_ready = idle && g1;

    assign core_a   = state == HI ? r.a[OP_W-1:ADD_W] : r.a[ADD_W-1:0];
    assign core_b   = state == HI ? r.b[OP_W-1:ADD_W] : r.b[ADD_W-1:0];
    assign core_cin = state == HI ? carry : 1'b0;

    add16_core u_core (
        .a    (core_a),
        .b    (core_b),
        .cin  (core_cin),
        .sum  (core_sum),
        .cout (core_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            r      <= '0;
            ptr    <= 1'b0;
            carry  <= 1'b0;
            sum_lo <= '0;
            sum_hi <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req0_ready || bus.req1_ready) begin
                    r     <= g1 ? {bus.req1_a, bus.req1_b, bus.req1_wide, 1'b1}
                                : {bus.req0_a, bus.req0_b, bus.req0_wide, 1'b0};
                    ptr   <= !g1;
                    state <= LO;
                end
                LO: begin
                    sum_lo <= core_sum;
                    carry  <= core_cout;
                    state  <= r.wide ? HI : RESP;
                end
                HI: begin
                    sum_hi <= core_sum;
                    carry  <= core_cout;
                    state  <= RESP;
                end
                RESP: if (bus.resp_ready) state <= IDLE;
            endcase
        end
    end

    assign bus.resp_valid = state == RESP;
    assign bus.busy       = state != IDLE;
    assign bus.resp_id    = r.id;
    assign bus.resp_carry = carry;
    assign bus.resp_sum   = {r.wide ? sum_hi : {ADD_W{1'b0}}, sum_lo};
endmodule

// File: tb/tb_adder_sched.sv
// tb_adder_sched: vector table, corner sequences and randomized model check
module tb_adder_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic m_ptr = 1'b0;
    logic m_id, m_c, m_w;
    logic [31:0] m_sum;

    adder_sched_if bus();

    adder_sched dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic v0, v1;
        logic [31:0] a0, b0;
        logic w0;
        logic [31:0] a1, b1;
        logic w1;
        logic id;
        logic [31:0] sum;
        logic c;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a request, expect the grant the round-robin rule predicts, and
    // leave the model's expected result in m_*. Returns at the LO-cycle negedge.
    task automatic issue(input logic v0, input logic v1,
                         input logic [31:0] a0, input logic [31:0] b0, input logic w0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic w1);
        logic [32:0] s;
        logic [31:0] a, b;
        int n = 0;
        @(negedge clk);
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_wide = w0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_wide = w1;
        #1;
        while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("grant_timeout", {32'd0, bus.req0_ready || bus.req1_ready}, 33'd1);
        m_id = (v0 && v1) ? m_ptr : v1;
        chk("grant", {31'd0, bus.req1_ready, bus.req0_ready}, {31'd0, m_id, !m_id});
        m_ptr = !m_id;
        a   = m_id ? a1 : a0;
        b   = m_id ? b1 : b0;
        m_w = m_id ? w1 : w0;
        s   = m_w ? {1'b0, a} + {1'b0, b} : {16'd0, {1'b0, a[15:0]} + {1'b0, b[15:0]}};
        m_sum = m_w ? s[31:0] : {16'd0, s[15:0]};
        m_c   = m_w ? s[32] : s[16];
        @(posedge clk);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    // Wait for the response, check latency and payload, stall for `stall`
    // cycles with both requesters knocking, then complete the handshake.
    task automatic collect(input logic id, input logic [31:0] sum, input logic c,
                           input logic w, input int stall);
        int lat = 1;
        while (!bus.resp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("resp_timeout", {32'd0, bus.resp_valid}, 33'd1);
        chk("latency", 33'(lat), w ? 33'd3 : 33'd2);
        chk("resp_id", {32'd0, bus.resp_id}, {32'd0, id});
        chk("resp_sum", {1'b0, bus.resp_sum}, {1'b0, sum});
        chk("resp_carry", {32'd0, bus.resp_carry}, {32'd0, c});
        for (int s = 0; s < stall; s++) begin
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            #1;
            chk("stall_readys", {31'd0, bus.req1_ready, bus.req0_ready}, 33'd0);
            chk("stall_stable", {bus.resp_valid, bus.resp_id, bus.resp_carry, bus.resp_sum[29:0]},
                {1'b1, id, c, sum[29:0]});
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("post_resp_idle", {31'd0, bus.resp_valid, bus.busy}, 33'd0);
    endtask

    initial begin
        vecs[0]  = '{1, 0, 32'h0000FFFF, 32'h00000001, 0, 32'h0, 32'h0, 0, 0, 32'h00000000, 1};
        vecs[1]  = '{0, 1, 32'h0, 32'h0, 0, 32'h0000FFFF, 32'h00000001, 1, 1, 32'h00010000, 0};
        vecs[2]  = '{1, 0, 32'hFFFFFFFF, 32'h00000001, 1, 32'h0, 32'h0, 0, 0, 32'h00000000, 1};
        vecs[3]  = '{0, 1, 32'h0, 32'h0, 0, 32'hABCD1234, 32'h11110001, 0, 1, 32'h00001235, 0};
        vecs[4]  = '{1, 1, 32'h00000001, 32'h00000002, 0, 32'h00000010, 32'h00000020, 0, 0, 32'h00000003, 0};
        vecs[5]  = '{1, 1, 32'h00000001, 32'h00000002, 0, 32'h00000010, 32'h00000020, 0, 1, 32'h00000030, 0};
        vecs[6]  = '{1, 1, 32'h80000000, 32'h80000000, 1, 32'h00000010, 32'h00000020, 0, 0, 32'h00000000, 1};
        vecs[7]  = '{1, 1, 32'h80000000, 32'h80000000, 1, 32'h1234FFFF, 32'h00010001, 1, 1, 32'h12360000, 0};
        vecs[8]  = '{0, 1, 32'h0, 32'h0, 0, 32'h00000005, 32'h00000007, 0, 1, 32'h0000000C, 0};
        vecs[9]  = '{0, 1, 32'h0, 32'h0, 0, 32'h0000FFFF, 32'h0000FFFF, 0, 1, 32'h0000FFFE, 1};
        vecs[10] = '{0, 1, 32'h0, 32'h0, 0, 32'h7FFFFFFF, 32'h00000001, 1, 1, 32'h80000000, 0};

        bus.req0_valid = 1'b1; bus.req0_a = '0; bus.req0_b = '0; bus.req0_wide = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = '0; bus.req1_b = '0; bus.req1_wide = 1'b0;
        bus.resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_readys", {31'd0, bus.req1_ready, bus.req0_ready}, 33'd0);
        chk("reset_resp", {bus.resp_valid, bus.resp_sum}, 33'd0);
        chk("reset_misc", {31'd0, bus.resp_id, bus.resp_carry}, 33'd0);
        chk("reset_busy", {32'd0, bus.busy}, 33'd0);
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].b0, vecs[i].w0,
                  vecs[i].a1, vecs[i].b1, vecs[i].w1);
            chk("vec_model_id", {32'd0, m_id}, {32'd0, vecs[i].id});
            collect(vecs[i].id, vecs[i].sum, vecs[i].c, m_w, i == 4 ? 5 : 0);
        end

        // Reset in HI of a wide op: the op is dropped and the pointer clears.
        issue(1, 0, 32'h12345678, 32'h11111111, 1, 32'h0, 32'h0, 0);
        @(negedge clk);
        chk("hi_busy", {31'd0, bus.busy, bus.resp_valid}, 33'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 1'b0;
        chk("midrst_idle", {31'd0, bus.resp_valid, bus.busy}, 33'd0);
        chk("midrst_resp", {bus.resp_id, bus.resp_sum}, 33'd0);
        bus.resp_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("dropped_no_resp", {32'd0, bus.resp_valid}, 33'd0);
        end
        bus.resp_ready = 1'b0;
        issue(1, 1, 32'h00000003, 32'h00000004, 0, 32'h00000009, 32'h00000009, 0);
        collect(1'b0, 32'h00000007, 1'b0, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            logic v0, v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            issue(v0, v1, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  $urandom, $urandom, 1'($urandom_range(0, 1)));
            collect(m_id, m_sum, m_c, m_w, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
